// File: rtl/usb_slave_fifo_writer_if.sv
// Signal bundle between the data FIFO / FX2 slave-FIFO writer and its surroundings.
// The writer itself uses the master view; a FIFO/FX2 model or host side uses slave.
interface usb_slave_fifo_writer_if;
    logic [15:0] DataFifoDout;
    logic        DataFifoEmpty;
    logic        DataFifoRdEn;
    logic        FlushRequest;
    logic        USB_FLAGB;
    logic        USB_SLWR_n;
    logic        USB_PKTEND_n;
    logic [1:0]  USB_FIFOADR;
    logic [15:0] USB_FD;
    logic        FlushDone;
    logic        TransferBusy;

    modport master (
        input  DataFifoDout, DataFifoEmpty, FlushRequest, USB_FLAGB,
        output DataFifoRdEn, USB_SLWR_n, USB_PKTEND_n, USB_FIFOADR, USB_FD,
               FlushDone, TransferBusy
    );

    modport slave (
        output DataFifoDout, DataFifoEmpty, FlushRequest, USB_FLAGB,
        input  DataFifoRdEn, USB_SLWR_n, USB_PKTEND_n, USB_FIFOADR, USB_FD,
               FlushDone, TransferBusy
    );
endinterface

// File: rtl/usb_slave_fifo_writer.sv
// Drains the 16-bit data FIFO into the FX2 slave-FIFO EP IN bus, one word per SLWR strobe,
// committing short packets with PKTEND on a flush request or after an idle timeout.
module usb_slave_fifo_writer #(
    parameter int         PACKET_WORDS      = 256,
    parameter int         IDLE_FLUSH_CYCLES = 4000,
    parameter logic [1:0] FIFO_ADDR         = 2'b10,
    localparam int        PCW               = $clog2(PACKET_WORDS),
    localparam int        ICW               = $clog2(IDLE_FLUSH_CYCLES + 1)
) (
    input  logic                    Clk,
    input  logic                    reset,
    usb_slave_fifo_writer_if.master bus,
    output logic [1:0]              dbg_state,
    output logic [PCW-1:0]          dbg_packet_count
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        WRITE  = 2'd2,
        PKTEND = 2'd3
    } state_t;

    localparam logic [PCW-1:0] PKT_LAST  = PCW'(PACKET_WORDS - 1);
    localparam logic [ICW-1:0] IDLE_LAST = ICW'(IDLE_FLUSH_CYCLES - 1);
    localparam logic [ICW-1:0] IDLE_MAX  = ICW'(IDLE_FLUSH_CYCLES);

    state_t         state, state_nxt;
    logic [PCW-1:0] pkt_cnt, pkt_cnt_nxt;
    logic [ICW-1:0] idle_cnt, idle_cnt_nxt;
    logic           flush_pending, flush_pending_nxt;
    logic           rd_en_q, rd_en_nxt;
    logic           slwr_n_q, slwr_n_nxt;
    logic           pktend_n_q, pktend_n_nxt;
    logic           flush_done_q, flush_done_nxt;
    logic           busy_q, busy_nxt;
    logic [15:0]    fd_q, fd_nxt;
    logic           idle_wait;

    assign idle_wait = (state == IDLE) && bus.DataFifoEmpty && (pkt_cnt != '0);

    always_comb begin
        state_nxt         = state;
        pkt_cnt_nxt       = pkt_cnt;
        flush_pending_nxt = flush_pending | bus.FlushRequest;
        rd_en_nxt         = 1'b0;
        slwr_n_nxt        = 1'b1;
        pktend_n_nxt      = 1'b1;
        flush_done_nxt    = 1'b0;
        fd_nxt            = fd_q;
        idle_cnt_nxt      = '0;

        if (idle_wait) begin
            idle_cnt_nxt = (idle_cnt == IDLE_MAX) ? idle_cnt : idle_cnt + 1'b1;
        end

        // Strobes are registered on the transition, so each is low/high while in its state.
        case (state)
            IDLE: begin
                if (!bus.DataFifoEmpty && bus.USB_FLAGB) begin
                    rd_en_nxt = 1'b1;
                    state_nxt = FETCH;
                end else if (bus.DataFifoEmpty && (pkt_cnt != '0) &&
                             (flush_pending || idle_cnt == IDLE_LAST)) begin
                    pktend_n_nxt = 1'b0;
                    pkt_cnt_nxt  = '0;
                    state_nxt    = PKTEND;
                    if (flush_pending) begin
                        flush_done_nxt    = 1'b1;
                        flush_pending_nxt = bus.FlushRequest;
                    end
                end else if (bus.DataFifoEmpty && flush_pending && (pkt_cnt == '0)) begin
                    flush_done_nxt    = 1'b1;
                    flush_pending_nxt = bus.FlushRequest;
                end
            end
            FETCH: begin
                state_nxt = WRITE;
            end
            WRITE: begin
                // Dout is valid here (read strobe was registered), so FD is captured now
                // and SLWR_n drops in the following cycle with FD already stable.
                fd_nxt      = bus.DataFifoDout;
                slwr_n_nxt  = 1'b0;
                pkt_cnt_nxt = (pkt_cnt == PKT_LAST) ? '0 : pkt_cnt + 1'b1;
                state_nxt   = IDLE;
            end
            PKTEND: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE) || (pkt_cnt_nxt != '0);
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            pkt_cnt       <= '0;
            idle_cnt      <= '0;
            flush_pending <= 1'b0;
            rd_en_q       <= 1'b0;
            slwr_n_q      <= 1'b1;
            pktend_n_q    <= 1'b1;
            flush_done_q  <= 1'b0;
            busy_q        <= 1'b0;
            fd_q          <= '0;
        end else begin
            state         <= state_nxt;
            pkt_cnt       <= pkt_cnt_nxt;
            idle_cnt      <= idle_cnt_nxt;
            flush_pending <= flush_pending_nxt;
            rd_en_q       <= rd_en_nxt;
            slwr_n_q      <= slwr_n_nxt;
            pktend_n_q    <= pktend_n_nxt;
            flush_done_q  <= flush_done_nxt;
            busy_q        <= busy_nxt;
            fd_q          <= fd_nxt;
        end
    end

    assign bus.DataFifoRdEn  = rd_en_q;
    assign bus.USB_SLWR_n    = slwr_n_q;
    assign bus.USB_PKTEND_n  = pktend_n_q;
    assign bus.USB_FIFOADR   = FIFO_ADDR;
    assign bus.USB_FD        = fd_q;
    assign bus.FlushDone     = flush_done_q;
    assign bus.TransferBusy  = busy_q;
    assign dbg_state         = state;
    assign dbg_packet_count  = pkt_cnt;
endmodule

// File: tb/tb_usb_slave_fifo_writer.sv
// Bench for usb_slave_fifo_writer: standard-mode FIFO model on the input side,
// scoreboard of expected FX2 words checked whenever SLWR_n is low.
module tb_usb_slave_fifo_writer;
    localparam int PACKET_WORDS = 256;
    localparam int IDLE_FLUSH   = 16;

    // Clock / reset
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    usb_slave_fifo_writer_if bus();
    logic [1:0] dbg_state;
    logic [7:0] dbg_packet_count;

    usb_slave_fifo_writer #(
        .PACKET_WORDS     (PACKET_WORDS),
        .IDLE_FLUSH_CYCLES(IDLE_FLUSH),
        .FIFO_ADDR        (2'b10)
    ) dut (
        .Clk             (clk),
        .reset           (reset),
        .bus             (bus),
        .dbg_state       (dbg_state),
        .dbg_packet_count(dbg_packet_count)
    );

    // Standard-mode data FIFO model: Dout valid the cycle after RdEn
    logic [15:0] fifo_mem [0:1023];
    int wr_ptr = 0;
    int rd_ptr = 0;
    always @(posedge clk) begin
        if (bus.DataFifoRdEn && rd_ptr != wr_ptr) begin
            bus.DataFifoDout <= fifo_mem[rd_ptr];
            rd_ptr           <= rd_ptr + 1;
        end
    end
    assign bus.DataFifoEmpty = (rd_ptr == wr_ptr);

    // Scoreboard state
    logic [15:0] exp_q[$];
    int slwr_cyc_q[$];
    int n_checks   = 0;
    int n_fail     = 0;
    int slwr_cnt   = 0;
    int pktend_cnt = 0;
    int done_cnt   = 0;
    int rden_cnt   = 0;
    int pktend_cyc = -1;
    int done_cyc   = -1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (!reset) begin
            if (!bus.USB_SLWR_n) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL slwr_unexpected: wrote 0x%0h, expected no write", bus.USB_FD);
                end else begin
                    check("slwr_data", int'(bus.USB_FD), int'(exp_q.pop_front()));
                end
                slwr_cnt++;
                slwr_cyc_q.push_back(cyc);
            end
            if (!bus.USB_PKTEND_n) begin
                check("pktend_excl_slwr", int'(bus.USB_SLWR_n), 1);
                pktend_cnt++;
                pktend_cyc = cyc;
            end
            if (bus.FlushDone) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (bus.DataFifoRdEn) rden_cnt++;
        end
    end

    // Driver tasks
    task automatic push_word(input logic [15:0] w, input bit expect_out);
        fifo_mem[wr_ptr] = w;
        wr_ptr++;
        if (expect_out) exp_q.push_back(w);
    endtask

    task automatic pulse_flush();
        bus.FlushRequest = 1'b1;
        @(negedge clk);
        bus.FlushRequest = 1'b0;
    endtask

    function automatic int cnt_of(input int which);
        case (which)
            0:       return slwr_cnt;
            1:       return pktend_cnt;
            default: return done_cnt;
        endcase
    endfunction

    task automatic wait_cnt(input int which, input int target, input int budget, input string name);
        int k = 0;
        while (cnt_of(which) < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, cnt_of(which), target);
    endtask

    int base_s, base_p, base_d, base_r;

    initial begin
        reset            = 1'b1;
        bus.FlushRequest = 1'b0;
        bus.USB_FLAGB    = 1'b1;
        repeat (3) @(negedge clk);

        check("rst_rden",     int'(bus.DataFifoRdEn), 0);
        check("rst_slwr_n",   int'(bus.USB_SLWR_n), 1);
        check("rst_pktend_n", int'(bus.USB_PKTEND_n), 1);
        check("rst_fd",       int'(bus.USB_FD), 0);
        check("rst_done",     int'(bus.FlushDone), 0);
        check("rst_busy",     int'(bus.TransferBusy), 0);
        check("rst_fifoadr",  int'(bus.USB_FIFOADR), 2);
        check("rst_state",    int'(dbg_state), 0);
        check("rst_count",    int'(dbg_packet_count), 0);
        reset = 1'b0;
        @(negedge clk);

        // T1 + T5: three words, 3-cycle spacing, then idle-timeout PKTEND 16 cycles later
        base_s = slwr_cnt; base_p = pktend_cnt; base_d = done_cnt;
        push_word(16'h1111, 1'b1);
        push_word(16'h2222, 1'b1);
        push_word(16'h3333, 1'b1);
        wait_cnt(0, base_s + 3, 40, "t1_writes");
        if (slwr_cyc_q.size() >= base_s + 3) begin
            check("t1_gap1", slwr_cyc_q[base_s+1] - slwr_cyc_q[base_s], 3);
            check("t1_gap2", slwr_cyc_q[base_s+2] - slwr_cyc_q[base_s+1], 3);
        end
        check("t1_no_pktend", pktend_cnt, base_p);
        check("t1_busy", int'(bus.TransferBusy), 1);
        check("t1_count", int'(dbg_packet_count), 3);
        wait_cnt(1, base_p + 1, 40, "t5_pktend");
        if (slwr_cyc_q.size() >= base_s + 3)
            check("t5_delay", pktend_cyc - slwr_cyc_q[base_s+2], IDLE_FLUSH);
        check("t5_no_done", done_cnt, base_d);
        @(negedge clk);
        check("t5_count_clr", int'(dbg_packet_count), 0);

        // T2: full packet then flush -> wrap to 0, no PKTEND, one FlushDone
        base_s = slwr_cnt; base_p = pktend_cnt; base_d = done_cnt;
        for (int i = 0; i < PACKET_WORDS; i++) push_word(16'hA000 + 16'(i), 1'b1);
        pulse_flush();
        wait_cnt(0, base_s + PACKET_WORDS, PACKET_WORDS * 3 + 50, "t2_writes");
        wait_cnt(2, base_d + 1, 20, "t2_done");
        repeat (5) @(negedge clk);
        check("t2_no_pktend", pktend_cnt, base_p);
        check("t2_done_once", done_cnt, base_d + 1);
        check("t2_count", int'(dbg_packet_count), 0);

        // T3: five words, flush during word 2 -> PKTEND after last word, FlushDone with it
        base_s = slwr_cnt; base_p = pktend_cnt; base_d = done_cnt;
        for (int i = 0; i < 5; i++) push_word(16'h3100 + 16'(i), 1'b1);
        wait_cnt(0, base_s + 1, 20, "t3_first");
        pulse_flush();
        wait_cnt(0, base_s + 5, 40, "t3_writes");
        wait_cnt(1, base_p + 1, 20, "t3_pktend");
        wait_cnt(2, base_d + 1, 20, "t3_done");
        if (slwr_cyc_q.size() >= base_s + 5)
            check("t3_pktend_after_last", pktend_cyc, slwr_cyc_q[base_s+4] + 1);
        check("t3_done_with_pktend", done_cyc, pktend_cyc);
        repeat (3) @(negedge clk);
        check("t3_pktend_once", pktend_cnt, base_p + 1);
        check("t3_count", int'(dbg_packet_count), 0);

        // T4: FLAGB low holds everything, then ten words in order
        base_s = slwr_cnt; base_p = pktend_cnt; base_d = done_cnt; base_r = rden_cnt;
        bus.USB_FLAGB = 1'b0;
        for (int i = 0; i < 10; i++) push_word(16'h4000 + 16'(i * 7), 1'b1);
        repeat (50) @(negedge clk);
        check("t4_hold_rden", rden_cnt, base_r);
        check("t4_hold_slwr", slwr_cnt, base_s);
        check("t4_hold_state", int'(dbg_state), 0);
        bus.USB_FLAGB = 1'b1;
        wait_cnt(0, base_s + 10, 60, "t4_writes");
        check("t4_reads", rden_cnt, base_r + 10);
        check("t4_count", int'(dbg_packet_count), 10);
        pulse_flush();
        wait_cnt(1, base_p + 1, 20, "t4_pktend");
        wait_cnt(2, base_d + 1, 20, "t4_done");

        // T6: reset while SLWR_n is low on the second word; that word is lost
        base_s = slwr_cnt;
        push_word(16'hC001, 1'b1);
        push_word(16'hC002, 1'b0);
        wait_cnt(0, base_s + 1, 20, "t6_first");
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (!bus.USB_SLWR_n) break;
        end
        check("t6_slwr_low", int'(bus.USB_SLWR_n), 0);
        check("t6_count_before", int'(dbg_packet_count), 2);
        reset = 1'b1;
        #1;
        check("t6_slwr_async", int'(bus.USB_SLWR_n), 1);
        check("t6_count_rst", int'(dbg_packet_count), 0);
        check("t6_state_rst", int'(dbg_state), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        push_word(16'hC003, 1'b1);
        wait_cnt(0, base_s + 2, 20, "t6_after");
        check("t6_count_restart", int'(dbg_packet_count), 1);

        check("exp_q_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
